booth_mul_ctrl: RTL and testbench

BOOTH_MUL_CTRL -- requirements
Module: booth_mul_ctrl

---
 rtl/booth_pkg.sv | 30 +++
 rtl/cla_adder_n.sv | 68 ++++++
 rtl/booth_mul_ctrl.sv | 100 ++++++++++
 tb/tb_booth_mul_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared FSM encodings and radix-4 Booth digit select codes for the
// sequential multiplier.
package booth_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ITER = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      PM   = 3'd1,
      P2M  = 3'd2,
      NM   = 3'd3,
      N2M  = 3'd4
   } booth_sel_e;

   // Maps the Booth window {Q[1], Q[0], q_m1} to the addend to apply.
   function automatic booth_sel_e booth_decode(input logic [2:0] bits);
      booth_sel_e sel;
      case (bits)
         3'b001, 3'b010: sel = PM;
         3'b011:         sel = P2M;
         3'b100:         sel = N2M;
         3'b101, 3'b110: sel = NM;
         default:        sel = ZERO;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/cla_adder_n.sv
// N-bit adder built from 4-bit carry-lookahead units; operands are
// zero-padded up to a multiple of 4 bits internally.
module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:1] c;

   assign g = a & b;
   assign p = a ^ b;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);
   assign sum  = p ^ {c[3:1], cin};
   assign cout = c[4];
endmodule

module cla_adder_n #(
   parameter int N = 18
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);
   localparam int NB = (N + 3) / 4;
   localparam int NP = NB * 4;

   logic [NP-1:0] a_pad;
   logic [NP-1:0] b_pad;
   logic [NP-1:0] s_pad;
   logic [NB:0]   carry;
   logic          unused_bits;

   assign a_pad    = NP'(a);
   assign b_pad    = NP'(b);
   assign carry[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_blk
         cla4 u_cla4 (
            .a    (a_pad[gi*4 +: 4]),
            .b    (b_pad[gi*4 +: 4]),
            .cin  (carry[gi]),
            .sum  (s_pad[gi*4 +: 4]),
            .cout (carry[gi+1])
         );
      end
      // With zero padding, the carry out of bit N-1 surfaces as pad sum bit N.
      if (NP == N) begin : g_exact
         assign cout = carry[NB];
      end else begin : g_padded
         assign cout = s_pad[N];
      end
   endgenerate

   assign sum         = s_pad[N-1:0];
   assign unused_bits = ^{s_pad, carry[NB]};
endmodule

// File: rtl/booth_mul_ctrl.sv
// Radix-4 Booth sequential signed multiplier: WIDTH/2 iterations through a
// single shared carry-lookahead adder.
module booth_mul_ctrl
   import booth_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);
   localparam int AW = WIDTH + 2;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

   logic [1:0]       state;
   logic [AW-1:0]    a_reg;
   logic [AW-1:0]    m_reg;
   logic [WIDTH-1:0] q_reg;
   logic             q_m1;
   logic [CW-1:0]    cnt;

   booth_sel_e       sel;
   logic [AW-1:0]    operand;
   logic             cin;
   logic [AW-1:0]    sum;
   logic             cout_unused;

   // Subtraction reuses the adder as A + ~operand + 1.
   always_comb begin
      sel     = booth_decode({q_reg[1:0], q_m1});
      operand = '0;
      cin     = 1'b0;
      case (sel)
         PM:  operand = m_reg;
         P2M: operand = {m_reg[AW-2:0], 1'b0};
         NM: begin
            operand = ~m_reg;
            cin     = 1'b1;
         end
         N2M: begin
            operand = ~{m_reg[AW-2:0], 1'b0};
            cin     = 1'b1;
         end
         default: operand = '0;
      endcase
   end

   cla_adder_n #(.N(AW)) u_add (
      .a    (a_reg),
      .b    (operand),
      .cin  (cin),
      .sum  (sum),
      .cout (cout_unused)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         a_reg <= '0;
         m_reg <= '0;
         q_reg <= '0;
         q_m1  <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_reg <= '0;
                  m_reg <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
                  q_reg <= multiplier;
                  q_m1  <= 1'b0;
                  cnt   <= '0;
                  state <= S_ITER;
               end
            end
            S_ITER: begin
               a_reg <= {sum[AW-1], sum[AW-1], sum[AW-1:2]};
               q_reg <= {sum[1:0], q_reg[WIDTH-1:2]};
               q_m1  <= q_reg[1];
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy    = (state == S_ITER) || (state == S_DONE);
   assign done    = (state == S_DONE);
   assign product = {a_reg[WIDTH-1:0], q_reg};
endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Scoreboard bench for booth_mul_ctrl: directed vectors, ignored starts,
// reset abort, and back-to-back random operands against a reference product.
module tb_booth_mul_ctrl;
   localparam int W = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [W-1:0]    multiplicand;
   logic [W-1:0]    multiplier;
   logic            busy;
   logic            done;
   logic [2*W-1:0]  product;

   int checks   = 0;
   int failures = 0;

   logic [2*W-1:0] exp_q[$];
   logic [2*W-1:0] last_product;
   logic           held = 1'b0;
   int             txn  = 0;

   booth_mul_ctrl #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard on each done pulse and checks the held result.
   always @(negedge clk) begin
      if (rst) begin
         held = 1'b0;
      end else begin
         if (done) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=0x%0h required=no_done", product);
            end else begin
               logic [2*W-1:0] e;
               e = exp_q.pop_front();
               txn++;
               check("product", {32'd0, product}, {32'd0, e});
               $display("txn %0d: product=0x%08h expected=0x%08h", txn, product, e);
            end
            last_product = product;
            held = 1'b1;
         end else if (held && !busy) begin
            check("product_held", {32'd0, product}, {32'd0, last_product});
         end
      end
   end

   // Issues one multiply from an IDLE cycle and returns in the following IDLE cycle.
   task automatic run_mul(input logic [W-1:0] m, input logic [W-1:0] q,
                          input logic [2*W-1:0] exp, input bit repulse, input bit timing);
      int  n;
      bit  seen;
      bit  busy_ok;
      multiplicand = m;
      multiplier   = q;
      start        = 1'b1;
      exp_q.push_back(exp);
      @(negedge clk);
      if (timing) check("busy_cycle0", {63'd0, busy}, 64'd0);
      @(posedge clk);
      #1;
      start   = 1'b0;
      seen    = 1'b0;
      busy_ok = 1'b1;
      for (n = 1; n <= 20; n++) begin
         if (repulse && (n == 3 || n == 9)) begin
            start        = 1'b1;
            multiplicand = 16'h1234;
            multiplier   = 16'h4321;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (!busy) busy_ok = 1'b0;
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=no_done required=done_within_20_cycles");
      end else begin
         if (timing) begin
            check("done_latency", 64'(n), 64'(W / 2 + 1));
            check("busy_window", {63'd0, busy_ok}, 64'd1);
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (timing) check("idle_after_done", {62'd0, busy, done}, 64'd0);
      end
   endtask

   typedef struct {
      logic [W-1:0]   m;
      logic [W-1:0]   q;
      logic [2*W-1:0] p;
   } vec_t;

   vec_t vecs[$] = '{
      '{16'h8000, 16'h8000, 32'h40000000},
      '{16'h7FFF, 16'h8000, 32'hC0008000},
      '{16'h8000, 16'h7FFF, 32'hC0008000},
      '{16'h7FFF, 16'h7FFF, 32'h3FFF0001},
      '{16'h8000, 16'h0001, 32'hFFFF8000},
      '{16'hFFFF, 16'h8000, 32'h00008000},
      '{16'hFFFF, 16'hFFFF, 32'h00000001},
      '{16'h0000, 16'h1234, 32'h00000000},
      '{16'h0100, 16'h0100, 32'h00010000},
      '{16'h0007, 16'hFFFD, 32'hFFFFFFEB}
   };

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);
      check("reset_product", {32'd0, product}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_mul(16'd3, 16'd5, 32'h0000000F, 1'b0, 1'b1);
      foreach (vecs[i]) run_mul(vecs[i].m, vecs[i].q, vecs[i].p, 1'b0, 1'b0);
      run_mul(16'hFFFF, 16'h0001, 32'hFFFFFFFF, 1'b1, 1'b1);

      // Abort a multiply in its fourth cycle; no done may follow.
      multiplicand = 16'h0123;
      multiplier   = 16'h0456;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_done", {63'd0, done}, 64'd0);
      check("abort_product", {32'd0, product}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_mul(16'd2, 16'hFFFD, 32'hFFFFFFFA, 1'b0, 1'b1);

      for (int k = 0; k < 1000; k++) begin
         logic [W-1:0]   rm;
         logic [W-1:0]   rq;
         logic [2*W-1:0] rp;
         rm = W'($urandom);
         rq = W'($urandom);
         rp = 32'($signed(rm)) * 32'($signed(rq));
         run_mul(rm, rq, rp, 1'b0, 1'b0);
      end

      repeat (4) @(posedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
